fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequencer for the program-counter register and the instruction-memory fetch port.
- Owns the PC register's write enable and write data, issues one fetch at a time from the current PC, and hands fetched instructions to decode over valid/ready.
- Arbitrates PC updates between trap entry, branch/jump redirect and sequential +4, squashing in-flight fetches on redirect.
- Sits between the PC register, the imem port, the EX stage (redirect) and the CSR unit (trap).

Parameters:
- RESET_VEC, 64'h80000000, boot address written to PC in the first cycle after reset release.
- ILEN_BYTES, 4, sequential PC increment.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_rdata  in  64  current PC register value.
- pc_we  out  1  PC write enable.
- pc_wdata  out  64  next PC value.
- imem_req_valid  out  1  fetch request.
- imem_req_ready  in  1  imem accepts the request.
- imem_req_addr  out  64  fetch address; equals pc_rdata.
- imem_resp_valid  in  1  fetch data valid; one response per accepted request, at the earliest one cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts the instruction.
- if_pc  out  64  PC of the offered instruction.
- if_instr  out  32  offered instruction.
- redirect_valid  in  1  branch/jump taken, one-cycle pulse.
- redirect_pc  in  64  redirect target.
- trap_valid  in  1  trap/mret entry, one-cycle pulse.
- trap_pc  in  64  trap vector or mepc.
- halt  in  1  suppress new fetch requests while high.
- fetch_cnt  out  CNT_W  instructions handed to decode.
- flush_cnt  out  CNT_W  accepted redirects plus traps.

Behaviour:
- Reset (async assert, sync release):
  - state=BOOT.
  - All outputs 0: pc_we, imem_req_valid, if_valid, if_pc, if_instr, both counters.
- States:
  - BOOT: pc_we=1, pc_wdata=RESET_VEC for exactly one cycle, then REQ.
  - REQ: imem_req_valid = !halt; imem_req_addr = pc_rdata. Handshake (valid && ready) -> WAIT.
  - WAIT: on imem_resp_valid, capture if_instr=resp_data and if_pc=pc_rdata -> HOLD.
  - HOLD: if_valid=1. On if_valid && if_ready: pc_we=1, pc_wdata = pc_rdata + ILEN_BYTES (mod 2^64, wraps), fetch_cnt++ -> REQ.
  - FLUSH: a request is outstanding to a stale address. The next imem_resp_valid is discarded -> REQ.
- PC update priority in any non-BOOT state: trap_valid > redirect_valid > sequential.
  - Winner drives pc_we=1, pc_wdata=trap_pc or redirect_pc; flush_cnt++.
  - A redirect in the same cycle as a trap is dropped and not counted.
- Next state on trap/redirect:
  - From WAIT, or from REQ with a handshake in the same cycle -> FLUSH.
  - From REQ without handshake -> REQ; address changes next cycle.
  - From HOLD -> REQ; buffered instruction dropped, if_valid=0 next cycle. A simultaneous if_ready handshake is still counted in fetch_cnt, but the sequential update loses to the redirect.
  - From FLUSH -> FLUSH; PC updated, pending response still discarded.
  - BOOT ignores trap/redirect.
- At most one outstanding request. imem_req_valid is never asserted in WAIT, HOLD or FLUSH.
- halt affects only REQ; it does not cancel outstanding responses or drop HOLD.
- if_pc and if_instr are stable while if_valid && !if_ready.
- Counters wrap at 2^CNT_W.
- Async reset mid-fetch returns to BOOT; any late imem response is the memory model's responsibility.
- Latency with ready=1 and 1-cycle response:
  - Request cycle t, HOLD at t+2, next request t+3.
  - Sustained throughput: one instruction per 3 cycles.

Decomposition:
- fetch_pkg: state enum {BOOT, REQ, WAIT, HOLD, FLUSH}, RESET_VEC and ILEN_BYTES localparams, pc_sel enum {SEL_SEQ, SEL_REDIR, SEL_TRAP, SEL_BOOT}.
- Single module; the priority mux is inline. No sub-module needed.

Test Plan:
- Reset release, ready=1, resp 1 cycle after request:
  - cycle0 pc_we=1 wdata=0x80000000.
  - Request addr 0x80000000.
  - if_pc=0x80000000 with if_instr=resp.
  - After handshake, pc_wdata=0x80000004; fetch_cnt=1.
- HOLD with if_ready=0 for 5 cycles -> if_valid, if_pc, if_instr stable; no request, no pc_we; then if_ready=1 -> one increment.
- Redirect to 0x80001000 during WAIT -> pc_wdata=0x80001000, FLUSH; the following response is not presented. Next request addr 0x80001000; flush_cnt=1.
- trap_valid (trap_pc 0x80000100) together with redirect_valid (0x80002000) in HOLD -> pc_wdata=0x80000100, if_valid drops, flush_cnt +1 only.
- halt=1 in REQ for 4 cycles -> imem_req_valid=0 throughout; halt=0 -> request issued at unchanged PC.
- pc_rdata=0xFFFF_FFFF_FFFF_FFFC sequential advance -> pc_wdata=0x0. rst_n low mid-WAIT -> all outputs 0 immediately, BOOT sequence repeats.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state/select encodings and boot constants for the fetch sequencer.
package fetch_pkg;
    typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, FLUSH} state_t;
    typedef enum logic [1:0] {SEL_SEQ, SEL_REDIR, SEL_TRAP, SEL_BOOT} pc_sel_t;
    localparam logic [63:0] RESET_VEC = 64'h8000_0000;
    localparam int ILEN_BYTES = 4;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC update arbitration and single-outstanding imem fetch with a one-entry decode buffer.
module fetch_ctrl #(
    parameter logic [63:0] RESET_VEC = fetch_pkg::RESET_VEC,
    parameter int ILEN_BYTES = fetch_pkg::ILEN_BYTES,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [63:0]      pc_rdata,
    output logic             pc_we,
    output logic [63:0]      pc_wdata,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [63:0]      imem_req_addr,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic             if_valid,
    input  logic             if_ready,
    output logic [63:0]      if_pc,
    output logic [31:0]      if_instr,
    input  logic             redirect_valid,
    input  logic [63:0]      redirect_pc,
    input  logic             trap_valid,
    input  logic [63:0]      trap_pc,
    input  logic             halt,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import fetch_pkg::*;
    state_t state, next;
    pc_sel_t sel;
    logic hs, flush, capture;
    assign imem_req_addr = pc_rdata;
    assign imem_req_valid = state == REQ && !halt;
    assign if_valid = state == HOLD;
    assign hs = imem_req_valid && imem_req_ready;
    assign flush = state != BOOT && (trap_valid || redirect_valid);
    assign capture = state == WAIT && imem_resp_valid && !flush;
    // a response landing in the same cycle as a flush retires the outstanding request, so no FLUSH wait is needed
    always_comb begin
        sel = state == BOOT ? SEL_BOOT : trap_valid ? SEL_TRAP : redirect_valid ? SEL_REDIR : SEL_SEQ;
        pc_we = (state == BOOT && rst_n) || flush || (if_valid && if_ready);
        pc_wdata = sel == SEL_BOOT ? RESET_VEC : sel == SEL_TRAP ? trap_pc :
                   sel == SEL_REDIR ? redirect_pc : pc_rdata + 64'(ILEN_BYTES);
        next = state;
        case (state)
            BOOT:    next = REQ;
            REQ:     next = hs ? WAIT : REQ;
            WAIT:    next = imem_resp_valid ? HOLD : WAIT;
            HOLD:    next = if_ready ? REQ : HOLD;
            FLUSH:   next = imem_resp_valid ? REQ : FLUSH;
            default: next = BOOT;
        endcase
        if (flush)
            next = (hs || ((state == WAIT || state == FLUSH) && !imem_resp_valid)) ? FLUSH : REQ;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
            if_pc <= '0;
            if_instr <= '0;
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= next;
            if (capture) begin
                if_pc <= pc_rdata;
                if_instr <= imem_resp_data;
            end
            if (if_valid && if_ready)
                fetch_cnt <= fetch_cnt + CNT_W'(1);
            if (flush)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed vector table plus randomized run against a transaction-level fetch model.
module tb_fetch_ctrl;
    localparam logic [63:0] R = 64'h8000_0000;
    localparam logic [63:0] F = 64'hFFFF_FFFF_FFFF_FFFC;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [63:0] pc_rdata = '0, pc_wdata, imem_req_addr, if_pc, redirect_pc = '0, trap_pc = '0;
    logic pc_we, imem_req_valid, imem_req_ready = 0, imem_resp_valid = 0, if_valid, if_ready = 0;
    logic redirect_valid = 0, trap_valid = 0, halt = 0;
    logic [31:0] imem_resp_data = '0, if_instr, fetch_cnt, flush_cnt;
    int tests = 0, fails = 0;

    fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .pc_rdata(pc_rdata), .pc_we(pc_we), .pc_wdata(pc_wdata),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data), .if_valid(if_valid),
        .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .trap_valid(trap_valid), .trap_pc(trap_pc), .halt(halt),
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt));

    always #5 clk = ~clk;
    always @(posedge clk) if (pc_we) pc_rdata <= pc_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic halt, rdy, resp, ird, redir, trap;
        logic [63:0] rpc;
        logic [31:0] data;
        logic we;
        logic [63:0] wd;
        logic rv;
        logic [63:0] addr;
        logic iv;
        logic [63:0] ipc;
        logic [31:0] ins, fc, fl;
    } vec_t;
    vec_t tbl[$];

    typedef struct { logic [63:0] pc; logic [31:0] ins; } ent_t;
    ent_t bufq[$];
    logic booted, outst, stale, e_we, e_rv, e_iv, m_busy;
    logic [63:0] req_addr, e_wd, m_addr;
    logic [31:0] e_fc, e_fl;
    int m_delay;

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_C3C3;
    endfunction

    task automatic apply(input vec_t v, input int n);
        halt = v.halt; imem_req_ready = v.rdy; imem_resp_valid = v.resp; if_ready = v.ird;
        redirect_valid = v.redir; trap_valid = v.trap; redirect_pc = v.rpc; trap_pc = 64'h8000_0100;
        imem_resp_data = v.data;
        #1;
        chk($sformatf("v%0d pc_we", n), pc_we, v.we);
        if (v.we) chk($sformatf("v%0d pc_wdata", n), pc_wdata, v.wd);
        chk($sformatf("v%0d req_valid", n), imem_req_valid, v.rv);
        if (v.rv) chk($sformatf("v%0d req_addr", n), imem_req_addr, v.addr);
        chk($sformatf("v%0d if_valid", n), if_valid, v.iv);
        if (v.iv) begin
            chk($sformatf("v%0d if_pc", n), if_pc, v.ipc);
            chk($sformatf("v%0d if_instr", n), if_instr, v.ins);
        end
        chk($sformatf("v%0d fetch_cnt", n), fetch_cnt, v.fc);
        chk($sformatf("v%0d flush_cnt", n), flush_cnt, v.fl);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " pc_we"}, pc_we, 0);
        chk({tag, " req_valid"}, imem_req_valid, 0);
        chk({tag, " if_valid"}, if_valid, 0);
        chk({tag, " if_pc"}, if_pc, 0);
        chk({tag, " if_instr"}, if_instr, 0);
        chk({tag, " fetch_cnt"}, fetch_cnt, 0);
        chk({tag, " flush_cnt"}, flush_cnt, 0);
    endtask

    initial begin
        tbl.push_back(vec_t'{0,1,0,0,0,0, 0, 0,          1,R,    0,0,    0,0,0,          0,0});
        tbl.push_back(vec_t'{0,1,0,0,0,0, 0, 0,          0,0,    1,R,    0,0,0,          0,0});
        tbl.push_back(vec_t'{0,1,1,0,0,0, 0, 32'h1111_1111, 0,0, 0,0,    0,0,0,          0,0});
        tbl.push_back(vec_t'{0,1,0,1,0,0, 0, 0,          1,R+4,  0,0,    1,R,32'h1111_1111, 0,0});
        tbl.push_back(vec_t'{0,1,0,0,0,0, 0, 0,          0,0,    1,R+4,  0,0,0,          1,0});
        tbl.push_back(vec_t'{0,1,1,0,0,0, 0, 32'h2222_2222, 0,0, 0,0,    0,0,0,          1,0});
        for (int i = 0; i < 5; i++)
            tbl.push_back(vec_t'{0,1,0,0,0,0, 0, 0,      0,0,    0,0,    1,R+4,32'h2222_2222, 1,0});
        tbl.push_back(vec_t'{0,1,0,1,0,0, 0, 0,          1,R+8,  0,0,    1,R+4,32'h2222_2222, 1,0});
        tbl.push_back(vec_t'{0,1,0,0,0,0, 0, 0,          0,0,    1,R+8,  0,0,0,          2,0});
        tbl.push_back(vec_t'{0,1,0,0,1,0, 64'h8000_1000, 0, 1,64'h8000_1000, 0,0, 0,0,0, 2,0});
        tbl.push_back(vec_t'{0,1,1,0,0,0, 0, 32'h3333_3333, 0,0, 0,0,    0,0,0,          2,1});
        tbl.push_back(vec_t'{0,1,0,0,0,0, 0, 0,          0,0,    1,64'h8000_1000, 0,0,0, 2,1});
        tbl.push_back(vec_t'{0,1,1,0,0,0, 0, 32'h4444_4444, 0,0, 0,0,    0,0,0,          2,1});
        tbl.push_back(vec_t'{0,1,0,0,1,1, 64'h8000_2000, 0, 1,64'h8000_0100, 0,0, 1,64'h8000_1000,32'h4444_4444, 2,1});
        for (int i = 0; i < 4; i++)
            tbl.push_back(vec_t'{1,1,0,0,0,0, 0, 0,      0,0,    0,0,    0,0,0,          2,2});
        tbl.push_back(vec_t'{0,1,0,0,0,0, 0, 0,          0,0,    1,64'h8000_0100, 0,0,0, 2,2});
        tbl.push_back(vec_t'{0,1,1,0,0,0, 0, 32'h5555_5555, 0,0, 0,0,    0,0,0,          2,2});
        tbl.push_back(vec_t'{0,1,0,0,1,0, F, 0,          1,F,    0,0,    1,64'h8000_0100,32'h5555_5555, 2,2});
        tbl.push_back(vec_t'{0,1,0,0,0,0, 0, 0,          0,0,    1,F,    0,0,0,          2,3});
        tbl.push_back(vec_t'{0,1,1,0,0,0, 0, 32'h6666_6666, 0,0, 0,0,    0,0,0,          2,3});
        tbl.push_back(vec_t'{0,1,0,1,0,0, 0, 0,          1,0,    0,0,    1,F,32'h6666_6666, 2,3});
        tbl.push_back(vec_t'{0,0,0,0,0,0, 0, 0,          0,0,    1,0,    0,0,0,          3,3});
        tbl.push_back(vec_t'{0,1,0,0,0,0, 0, 0,          0,0,    1,0,    0,0,0,          3,3});
        tbl.push_back(vec_t'{0,0,0,0,0,0, 0, 0,          0,0,    0,0,    0,0,0,          3,3});

        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            apply(tbl[i], i);
            if (i != tbl.size() - 1) @(negedge clk);
        end
        // last row sits in WAIT with a request outstanding; reset must clear outputs immediately
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        chk("reboot pc_we", pc_we, 1);
        chk("reboot pc_wdata", pc_wdata, R);
        @(negedge clk);
        #1;
        chk("reboot req_valid", imem_req_valid, 1);
        chk("reboot req_addr", imem_req_addr, R);

        rst_n = 1'b0;
        imem_resp_valid = 1'b0;
        booted = 0; outst = 0; stale = 0; m_busy = 0; m_delay = 0; m_addr = '0; req_addr = '0;
        e_fc = '0; e_fl = '0;
        bufq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            halt = ($urandom % 4) == 0;
            imem_req_ready = ($urandom % 3) != 0;
            if_ready = 1'($urandom % 2);
            redirect_valid = ($urandom % 8) == 0;
            trap_valid = ($urandom % 16) == 0;
            redirect_pc = ($urandom % 16) == 0 ? F : R + 64'($urandom_range(0, 1023)) * 4;
            trap_pc = R + 64'($urandom_range(0, 63)) * 4;
            imem_resp_valid = m_busy && m_delay == 0;
            imem_resp_data = mdata(m_addr);
            #1;
            e_rv = booted && !outst && bufq.size() == 0 && !halt;
            e_iv = bufq.size() != 0;
            e_we = 1'b1;
            e_wd = !booted ? R : trap_valid ? trap_pc : redirect_valid ? redirect_pc : pc_rdata + 64'd4;
            if (booted && !trap_valid && !redirect_valid && !(e_iv && if_ready)) e_we = 1'b0;
            chk("rnd pc_we", pc_we, e_we);
            if (e_we) chk("rnd pc_wdata", pc_wdata, e_wd);
            chk("rnd req_valid", imem_req_valid, e_rv);
            if (e_rv) chk("rnd req_addr", imem_req_addr, pc_rdata);
            chk("rnd if_valid", if_valid, e_iv);
            if (e_iv) begin
                chk("rnd if_pc", if_pc, bufq[0].pc);
                chk("rnd if_instr", if_instr, bufq[0].ins);
            end
            chk("rnd fetch_cnt", fetch_cnt, e_fc);
            chk("rnd flush_cnt", flush_cnt, e_fl);
            if (!booted) booted = 1'b1;
            else begin
                if (e_iv && if_ready) begin
                    e_fc++;
                    void'(bufq.pop_front());
                end
                if (trap_valid || redirect_valid) e_fl++;
                if (imem_resp_valid && outst) begin
                    outst = 1'b0;
                    if (!stale && !(trap_valid || redirect_valid))
                        bufq.push_back(ent_t'{req_addr, imem_resp_data});
                    stale = 1'b0;
                end
                if (e_rv && imem_req_ready) begin
                    outst = 1'b1;
                    stale = 1'b0;
                    req_addr = pc_rdata;
                end
                if (trap_valid || redirect_valid) begin
                    if (outst) stale = 1'b1;
                    bufq.delete();
                end
            end
            if (imem_resp_valid) m_busy = 1'b0;
            else if (m_busy) m_delay--;
            if (imem_req_valid && imem_req_ready) begin
                m_busy = 1'b1;
                m_delay = $urandom_range(0, 2);
                m_addr = imem_req_addr;
            end
            @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
